// File: rtl/seg7_scan_display_if.sv
// Value and display bundle between the BCD producer and the multiplexed 7-segment driver.
// The master presents digits and a load strobe; the slave drives segments, anodes and the frame pulse.
interface seg7_scan_display_if;
   logic       load;
   logic [3:0] bcd0;
   logic [3:0] bcd1;
   logic [3:0] bcd2;
   logic       neg;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame;

   modport master (
      output load, bcd0, bcd1, bcd2, neg,
      input  seg, an, frame
   );

   modport slave (
      input  load, bcd0, bcd1, bcd2, neg,
      output seg, an, frame
   );
endinterface

// File: rtl/seg7_scan_display.sv
// Double-buffered 3-digit-plus-sign scanner for a 4-digit common-anode 7-segment display.
// Leading-zero blanking, a floating minus sign and per-slot anti-ghost blanking; updates land at frame boundaries.
module seg7_scan_display #(
   parameter int CLK_HZ      = 50_000_000,
   parameter int REFRESH_HZ  = 1000,
   parameter int BLANK_CYC   = 16,
   parameter int SEG_ACT_LOW = 1,
   parameter int AN_ACT_LOW  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   seg7_scan_display_if.slave  bus
);

   localparam int DIV_RAW = CLK_HZ / (REFRESH_HZ * 4);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int BLANK   = (BLANK_CYC > DIV - 1) ? DIV - 1 : BLANK_CYC;
   localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
   localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK);
   localparam logic [6:0]    SEG_OFF   = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [3:0]    AN_OFF    = (AN_ACT_LOW != 0) ? 4'hF : 4'h0;
   localparam logic [6:0]    PAT_MINUS = 7'h40;
   localparam logic [6:0]    PAT_BLANK = 7'h00;

   function automatic logic [6:0] digit_pat(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h79;
      endcase
      return p;
   endfunction

   logic [PW-1:0] presc_r;
   logic [1:0]    slot_r;
   logic [3:0]    pend_d0_r, pend_d1_r, pend_d2_r;
   logic          pend_neg_r, pend_vld_r;
   logic [3:0]    shd_d0_r, shd_d1_r, shd_d2_r;
   logic          shd_neg_r;
   logic [6:0]    seg_r;
   logic [3:0]    an_r;
   logic          frame_r;

   logic [PW-1:0] presc_nx_s;
   logic [1:0]    slot_nx_s;
   logic          wrap_s;
   logic          boundary_s;
   logic          blank2_s, blank1_s, zero_s, minus_s;
   logic [1:0]    minus_pos_s;
   logic [6:0]    pat_s;
   logic [3:0]    onehot_s;

   // Prescaler / slot sequencing and frame-boundary detection.
   always_comb begin
      wrap_s = (presc_r == PRESC_MAX);
      if (wrap_s) begin
         presc_nx_s = '0;
         slot_nx_s  = slot_r + 2'd1;
      end else begin
         presc_nx_s = presc_r + PW'(1);
         slot_nx_s  = slot_r;
      end
      boundary_s = wrap_s && (slot_r == 2'd3);
   end

   // Scan counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= '0;
         slot_r  <= 2'd0;
      end else begin
         presc_r <= presc_nx_s;
         slot_r  <= slot_nx_s;
      end
   end

   // Pending/shadow double buffer; a load on the boundary bypasses pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_d0_r  <= 4'd0;
         pend_d1_r  <= 4'd0;
         pend_d2_r  <= 4'd0;
         pend_neg_r <= 1'b0;
         pend_vld_r <= 1'b0;
         shd_d0_r   <= 4'd0;
         shd_d1_r   <= 4'd0;
         shd_d2_r   <= 4'd0;
         shd_neg_r  <= 1'b0;
      end else if (boundary_s) begin
         pend_vld_r <= 1'b0;
         if (bus.load) begin
            shd_d0_r  <= bus.bcd0;
            shd_d1_r  <= bus.bcd1;
            shd_d2_r  <= bus.bcd2;
            shd_neg_r <= bus.neg;
         end else if (pend_vld_r) begin
            shd_d0_r  <= pend_d0_r;
            shd_d1_r  <= pend_d1_r;
            shd_d2_r  <= pend_d2_r;
            shd_neg_r <= pend_neg_r;
         end
      end else if (bus.load) begin
         pend_d0_r  <= bus.bcd0;
         pend_d1_r  <= bus.bcd1;
         pend_d2_r  <= bus.bcd2;
         pend_neg_r <= bus.neg;
         pend_vld_r <= 1'b1;
      end
   end

   // Blanking and minus placement; the minus sits just left of the leading shown digit.
   always_comb begin
      blank2_s = (shd_d2_r == 4'd0);
      blank1_s = blank2_s && (shd_d1_r == 4'd0);
      zero_s   = blank1_s && (shd_d0_r == 4'd0);
      minus_s  = shd_neg_r && !zero_s;
      if (!blank2_s) begin
         minus_pos_s = 2'd3;
      end else if (!blank1_s) begin
         minus_pos_s = 2'd2;
      end else begin
         minus_pos_s = 2'd1;
      end
      onehot_s = 4'b0001 << slot_r;
      pat_s    = PAT_BLANK;
      if (minus_s && (slot_r == minus_pos_s)) begin
         pat_s = PAT_MINUS;
      end else begin
         case (slot_r)
            2'd0:    pat_s = digit_pat(shd_d0_r);
            2'd1:    pat_s = blank1_s ? PAT_BLANK : digit_pat(shd_d1_r);
            2'd2:    pat_s = blank2_s ? PAT_BLANK : digit_pat(shd_d2_r);
            default: pat_s = PAT_BLANK;
         endcase
      end
   end

   // Registered drive; blank-content slots keep their anode off too, so nothing ghosts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_r   <= SEG_OFF;
         an_r    <= AN_OFF;
         frame_r <= 1'b0;
      end else begin
         if ((presc_r < BLANK_LIM) || (pat_s == PAT_BLANK)) begin
            seg_r <= SEG_OFF;
            an_r  <= AN_OFF;
         end else begin
            seg_r <= pat_s ^ SEG_OFF;
            an_r  <= onehot_s ^ AN_OFF;
         end
         frame_r <= (presc_nx_s == PRESC_MAX) && (slot_nx_s == 2'd3);
      end
   end

   assign bus.seg   = seg_r;
   assign bus.an    = an_r;
   assign bus.frame = frame_r;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed table-driven bench for seg7_scan_display (DIV=4, one blank clock per slot, active-low drive).
module tb_seg7_scan_display;

   typedef struct {
      logic [3:0]  d2;
      logic [3:0]  d1;
      logic [3:0]  d0;
      logic        n;
      logic [27:0] pats;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   seg7_scan_display_if bus();

   seg7_scan_display #(
      .CLK_HZ(400), .REFRESH_HZ(25), .BLANK_CYC(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0,
                        input logic n, input logic ld);
      bus.bcd2 = d2;
      bus.bcd1 = d1;
      bus.bcd0 = d0;
      bus.neg  = n;
      bus.load = ld;
   endtask

   task automatic load_value(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0,
                             input logic n);
      drive(d2, d1, d0, n, 1'b1);
      step();
      bus.load = 1'b0;
   endtask

   task automatic wait_frame();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.frame) begin
            found = 1'b1;
            break;
         end
      end
      check("frame_wait", {31'd0, found}, 32'd1);
   endtask

   // Step k observes the output registered from scan index k (slot k/4, prescaler k%4).
   task automatic check_frame(input logic [27:0] pats, input string tag);
      int         s;
      int         p;
      logic [6:0] ep;
      logic [3:0] oh;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      for (int k = 0; k < 16; k++) begin
         step();
         s  = k / 4;
         p  = k % 4;
         ep = pats[s*7 +: 7];
         oh = 4'b0001 << s;
         if ((p == 0) || (ep == 7'h00)) begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
         end else begin
            exp_an  = ~oh;
            exp_seg = ~ep;
         end
         check({tag, "_an"}, {28'd0, bus.an}, {28'd0, exp_an});
         check({tag, "_seg"}, {25'd0, bus.seg}, {25'd0, exp_seg});
         check({tag, "_frame"}, {31'd0, bus.frame}, {31'd0, (k == 14)});
         check({tag, "_onehot"}, {31'd0, ($countones(~bus.an) <= 1)}, 32'd1);
      end
   endtask

   vec_t vecs[8];
   localparam logic [27:0] PATS_ZERO = {7'h00, 7'h00, 7'h00, 7'h3F};

   initial begin
      vecs[0] = '{4'd1, 4'd2, 4'd3, 1'b1, {7'h40, 7'h06, 7'h5B, 7'h4F}};
      vecs[1] = '{4'd0, 4'd0, 4'd7, 1'b1, {7'h00, 7'h00, 7'h40, 7'h07}};
      vecs[2] = '{4'd0, 4'd0, 4'd0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
      vecs[3] = '{4'd0, 4'hC, 4'd3, 1'b0, {7'h00, 7'h00, 7'h79, 7'h4F}};
      vecs[4] = '{4'd0, 4'd4, 4'd5, 1'b1, {7'h00, 7'h40, 7'h66, 7'h6D}};
      vecs[5] = '{4'd9, 4'd0, 4'd0, 1'b0, {7'h00, 7'h6F, 7'h3F, 7'h3F}};
      vecs[6] = '{4'hA, 4'd0, 4'd0, 1'b1, {7'h40, 7'h79, 7'h3F, 7'h3F}};
      vecs[7] = '{4'd0, 4'd0, 4'd0, 1'b0, {7'h00, 7'h00, 7'h00, 7'h3F}};

      drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      step();
      step();
      check("rst_an", {28'd0, bus.an}, 32'hF);
      check("rst_seg", {25'd0, bus.seg}, 32'h7F);
      check("rst_frame", {31'd0, bus.frame}, 32'd0);
      rst_n = 1'b1;
      check_frame(PATS_ZERO, "boot");

      foreach (vecs[i]) begin
         load_value(vecs[i].d2, vecs[i].d1, vecs[i].d0, vecs[i].n);
         wait_frame();
         step();
         check_frame(vecs[i].pats, $sformatf("vec%0d", i));
      end

      // Last load before the boundary wins.
      load_value(4'd0, 4'd0, 4'd5, 1'b0);
      step();
      step();
      step();
      load_value(4'd0, 4'd0, 4'd8, 1'b0);
      wait_frame();
      step();
      check_frame({7'h00, 7'h00, 7'h00, 7'h7F}, "lastwin");
      check_frame({7'h00, 7'h00, 7'h00, 7'h7F}, "lastwin2");

      // Load on the boundary cycle itself shows in the very next frame.
      wait_frame();
      drive(4'd0, 4'd0, 4'd4, 1'b0, 1'b1);
      step();
      bus.load = 1'b0;
      check_frame({7'h00, 7'h00, 7'h00, 7'h66}, "bndload");

      // Reset in the middle of slot 2 turns the display off at once.
      for (int i = 0; i < 9; i++) step();
      rst_n = 1'b0;
      #1;
      check("midrst_an", {28'd0, bus.an}, 32'hF);
      check("midrst_seg", {25'd0, bus.seg}, 32'h7F);
      check("midrst_frame", {31'd0, bus.frame}, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      check_frame(PATS_ZERO, "reboot");

      // Long soak against the slot scoreboard.
      load_value(4'd1, 4'd2, 4'd3, 1'b1);
      wait_frame();
      step();
      for (int f = 0; f < 1000; f++) begin
         check_frame(vecs[0].pats, "soak");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
